// File: rtl/pipe_pkg.sv
// Shared types for the forwarding controller: per-stage tag, sel-code width and the register-file sel code.
package pipe_pkg;

    // Widest register address a tag can carry; narrower addresses are stored zero-extended.
    localparam int RD_MAX_W = 16;
    localparam int SEL_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                load;
    } stage_tag_t;

    function automatic int SEL_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority matcher for one source operand: picks the youngest producing stage and decides forward vs hazard.
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int LOAD_STAGE = 1,
    parameter int SW         = SEL_W(DEPTH)
) (
    input  stage_tag_t [DEPTH-1:0] tags_i,
    input  logic [AW-1:0]          rs_i,
    input  logic                   use_i,
    input  logic [DW-1:0]          rf_data_i,
    input  logic [DEPTH*DW-1:0]    stage_result_i,
    output logic [SW-1:0]          sel_o,
    output logic [DW-1:0]          data_o,
    output logic                   hazard_o
);

    logic hit_s;
    logic hit_load_s;
    int   hit_idx_s;

    // Scan oldest to youngest so the youngest matching stage is the last one written.
    always_comb begin
        hit_s      = 1'b0;
        hit_load_s = 1'b0;
        hit_idx_s  = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tags_i[i].valid && tags_i[i].regwrite && use_i && (rs_i != {AW{1'b0}}) &&
                (tags_i[i].rd == RD_MAX_W'(rs_i))) begin
                hit_s      = 1'b1;
                hit_load_s = tags_i[i].load;
                hit_idx_s  = i;
            end else begin
                hit_s      = hit_s;
                hit_load_s = hit_load_s;
                hit_idx_s  = hit_idx_s;
            end
        end
    end

    // A load result is only usable once it has reached LOAD_STAGE; earlier it becomes a hazard.
    always_comb begin
        sel_o    = SW'(SEL_RF);
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        if (hit_s && (!hit_load_s || (hit_idx_s >= LOAD_STAGE))) begin
            sel_o  = SW'(hit_idx_s + 1);
            data_o = stage_result_i[hit_idx_s*DW +: DW];
        end else if (hit_s) begin
            hazard_o = 1'b1;
        end else begin
            hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_fwd_ctrl.sv
// Pipeline forwarding/stall controller with a per-stage tag shift register.
// Optional statistics counters are built when PIPE_FWD_STATS_EN is defined.
module pipe_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [AW-1:0]                id_rd,
    input  logic                         id_regwrite,
    input  logic                         id_memread,
    input  logic [NSRC*AW-1:0]           id_rs,
    input  logic [NSRC-1:0]              id_use,
    input  logic [NSRC*DW-1:0]           rf_data,
    input  logic [DEPTH*DW-1:0]          stage_result,
    input  logic                         flush_id,
    input  logic                         flush_ex,
    output logic                         stall,
    output logic [NSRC*SEL_W(DEPTH)-1:0] fwd_sel,
    output logic [NSRC*DW-1:0]           fwd_data,
    output logic [DEPTH-1:0]             stage_valid
`ifdef PIPE_FWD_STATS_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  fwd_cnt
`endif
);

    localparam int SW = SEL_W(DEPTH);

    stage_tag_t [DEPTH-1:0] tag_q;
    stage_tag_t [DEPTH-1:0] tag_d;
    stage_tag_t             id_tag_s;
    logic [NSRC-1:0]        hazard_s;

    // Decode-slot tag as it would enter stage 0.
    always_comb begin
        id_tag_s          = '0;
        id_tag_s.valid    = 1'b1;
        id_tag_s.rd       = RD_MAX_W'(id_rd);
        id_tag_s.regwrite = id_regwrite;
        id_tag_s.load     = id_memread;
    end

    assign stall = id_valid & ~flush_id & (|hazard_s);

    // Shift: stage 0 takes the decode tag or a bubble, flush_ex kills what would move into stage 1.
    always_comb begin
        tag_d = tag_q;
        if (id_valid && !stall && !flush_id && !flush_ex) begin
            tag_d[0] = id_tag_s;
        end else begin
            tag_d[0] = '0;
        end
        if (flush_ex) begin
            tag_d[1] = '0;
        end else begin
            tag_d[1] = tag_q[0];
        end
        for (int i = 2; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag register; reset empties the pipe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Expose the per-stage valid bits straight from the tag register.
    always_comb begin
        stage_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_valid[i] = tag_q[i].valid;
        end
    end

    for (genvar j = 0; j < NSRC; j++) begin : g_src
        pipe_fwd_match #(
            .DEPTH     (DEPTH),
            .DW        (DW),
            .AW        (AW),
            .LOAD_STAGE(LOAD_STAGE),
            .SW        (SW)
        ) u_match (
            .tags_i        (tag_q),
            .rs_i          (id_rs[j*AW +: AW]),
            .use_i         (id_use[j]),
            .rf_data_i     (rf_data[j*DW +: DW]),
            .stage_result_i(stage_result),
            .sel_o         (fwd_sel[j*SW +: SW]),
            .data_o        (fwd_data[j*DW +: DW]),
            .hazard_o      (hazard_s[j])
        );
    end

`ifdef PIPE_FWD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        any_fwd_s;

    assign any_fwd_s = id_valid & (|fwd_sel);

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
            fwd_cnt_q   <= 32'd0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (any_fwd_s && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end else begin
                fwd_cnt_q <= fwd_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Directed bench for pipe_fwd_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_fwd_ctrl;
    import pipe_pkg::*;

    localparam int DEPTH = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NSRC  = 2;
    localparam int SW    = SEL_W(DEPTH);

    localparam logic [DW-1:0] RF0 = 32'h1111_1111;
    localparam logic [DW-1:0] RF1 = 32'h2222_2222;
    localparam logic [DW-1:0] SR0 = 32'hA000_0000;
    localparam logic [DW-1:0] SR1 = 32'hB000_0001;
    localparam logic [DW-1:0] SR2 = 32'hC000_0002;

    logic                 clk;
    logic                 reset;
    logic                 id_valid;
    logic [AW-1:0]        id_rd;
    logic                 id_regwrite;
    logic                 id_memread;
    logic [NSRC*AW-1:0]   id_rs;
    logic [NSRC-1:0]      id_use;
    logic [NSRC*DW-1:0]   rf_data;
    logic [DEPTH*DW-1:0]  stage_result;
    logic                 flush_id;
    logic                 flush_ex;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic [NSRC*DW-1:0]   fwd_data;
    logic [DEPTH-1:0]     stage_valid;
`ifdef PIPE_FWD_STATS_EN
    logic [31:0]          stall_cnt;
    logic [31:0]          fwd_cnt;
`endif

    pipe_fwd_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .NSRC(NSRC), .LOAD_STAGE(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_rs       (id_rs),
        .id_use      (id_use),
        .rf_data     (rf_data),
        .stage_result(stage_result),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .fwd_data    (fwd_data),
        .stage_valid (stage_valid)
`ifdef PIPE_FWD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    typedef struct {
        string            name;
        logic             stall;
        logic [SW-1:0]    sel0;
        logic [SW-1:0]    sel1;
        logic [DEPTH-1:0] sv;
        logic             cnt_zero;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] exp_data(input logic [SW-1:0] sel, input logic [DW-1:0] rf);
        case (sel)
            2'd0:    return rf;
            2'd1:    return SR0;
            2'd2:    return SR1;
            2'd3:    return SR2;
            default: return 32'd0;
        endcase
    endfunction

    task automatic cmp(input string name, input string field, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational from tags and inputs, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "stall", 64'(stall), 64'(e.stall));
                cmp(e.name, "sel0", 64'(fwd_sel[SW-1:0]), 64'(e.sel0));
                cmp(e.name, "sel1", 64'(fwd_sel[2*SW-1:SW]), 64'(e.sel1));
                cmp(e.name, "data0", 64'(fwd_data[DW-1:0]), 64'(exp_data(e.sel0, RF0)));
                cmp(e.name, "data1", 64'(fwd_data[2*DW-1:DW]), 64'(exp_data(e.sel1, RF1)));
                cmp(e.name, "stage_valid", 64'(stage_valid), 64'(e.sv));
`ifdef PIPE_FWD_STATS_EN
                if (e.cnt_zero) begin
                    cmp(e.name, "stall_cnt", 64'(stall_cnt), 64'd0);
                    cmp(e.name, "fwd_cnt", 64'(fwd_cnt), 64'd0);
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic [AW-1:0] rs0, input logic [AW-1:0] rs1, input logic [1:0] use_b,
                         input logic fid, input logic fex);
        id_valid    = v;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_rs       = {rs1, rs0};
        id_use      = use_b;
        flush_id    = fid;
        flush_ex    = fex;
    endtask

    task automatic expect_out(input string name, input logic st, input logic [SW-1:0] s0,
                              input logic [SW-1:0] s1, input logic [DEPTH-1:0] sv, input logic cz);
        exp_t e;
        e.name = name; e.stall = st; e.sel0 = s0; e.sel1 = s1; e.sv = sv; e.cnt_zero = cz;
        q.push_back(e);
    endtask

    initial begin
        reset        = 1'b0;
        rf_data      = {RF1, RF0};
        stage_result = {SR2, SR1, SR0};
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 5'd8, 2'b11, 1'b0, 1'b0);
        expect_out("in_reset", 1'b0, 2'd0, 2'd0, 3'b000, 1'b1);
        step();
        reset = 1'b1;
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
        expect_out("add_r8", 1'b0, 2'd0, 2'd0, 3'b000, 1'b0);
        step();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 5'd3, 2'b11, 1'b0, 1'b0);
        expect_out("raw_stage0", 1'b0, 2'd1, 2'd0, 3'b001, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b1, 1'b1, 5'd10, 5'd8, 2'b11, 1'b0, 1'b0);
        expect_out("two_stage_fwd", 1'b0, 2'd1, 2'd2, 3'b011, 1'b0);
        step();
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd9, 5'd8, 2'b11, 1'b0, 1'b0);
        expect_out("load_use_stall", 1'b1, 2'd0, 2'd3, 3'b111, 1'b0);
        step();
        expect_out("load_after_stall", 1'b0, 2'd2, 2'd0, 3'b110, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 2'b00, 1'b0, 1'b0);
        expect_out("w_r5_a", 1'b0, 2'd0, 2'd0, 3'b101, 1'b0);
        step();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd1, 5'd2, 2'b00, 1'b0, 1'b0);
        expect_out("w_r6", 1'b0, 2'd0, 2'd0, 3'b011, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 2'b00, 1'b0, 1'b0);
        expect_out("w_r5_b", 1'b0, 2'd0, 2'd0, 3'b111, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd5, 5'd6, 2'b11, 1'b0, 1'b0);
        expect_out("youngest_wins", 1'b0, 2'd1, 2'd2, 3'b111, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd5, 2'b11, 1'b0, 1'b0);
        expect_out("r0_no_fwd", 1'b0, 2'd0, 2'd2, 3'b111, 1'b0);
        step();
        drive(1'b1, 5'd12, 1'b1, 1'b1, 5'd5, 5'd5, 2'b10, 1'b0, 1'b0);
        expect_out("use_flag", 1'b0, 2'd0, 2'd3, 3'b111, 1'b0);
        step();
        drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd12, 5'd1, 2'b11, 1'b0, 1'b1);
        expect_out("stall_with_flush_ex", 1'b1, 2'd0, 2'd0, 3'b111, 1'b0);
        step();
        drive(1'b0, 5'd12, 1'b1, 1'b0, 5'd12, 5'd7, 2'b11, 1'b0, 1'b0);
        expect_out("after_flush_ex", 1'b0, 2'd0, 2'd0, 3'b100, 1'b0);
        step();
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        expect_out("fill_1", 1'b0, 2'd0, 2'd0, 3'b000, 1'b0);
        step();
        drive(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        expect_out("fill_2", 1'b0, 2'd0, 2'd0, 3'b001, 1'b0);
        step();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        expect_out("fill_3", 1'b0, 2'd0, 2'd0, 3'b011, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 5'd2, 2'b11, 1'b0, 1'b0);
        expect_out("full_pipe", 1'b0, 2'd1, 2'd2, 3'b111, 1'b0);
        step();
        reset = 1'b0;
        expect_out("async_reset", 1'b0, 2'd0, 2'd0, 3'b000, 1'b1);
        step();
        reset = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd2, 2'b11, 1'b0, 1'b0);
        expect_out("restart_empty", 1'b0, 2'd0, 2'd0, 3'b000, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 1'b1, 1'b0);
        expect_out("flush_id_cycle", 1'b0, 2'd1, 2'd0, 3'b001, 1'b0);
        step();
        drive(1'b1, 5'd14, 1'b1, 1'b0, 5'd4, 5'd9, 2'b11, 1'b0, 1'b0);
        expect_out("after_flush_id", 1'b0, 2'd0, 2'd2, 3'b010, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
